// File: rtl/ebr_fifo_pkg.sv
// Shared constants and helpers for the EBR-backed stream FIFO.
// Geometry of the iCE40UP 4K-bit embedded block RAM.
package ebr_fifo_pkg;

  localparam int EBR_BITS = 4096;
  localparam int EBR_MIN_DEPTH = 16;
  localparam int EBR_MAX_DEPTH = 4096;
  localparam int EBR_MAX_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Native lane width of one block for a given payload width.
  function automatic int ebr_lane(input int w);
    if (w <= 2) return 2;
    if (w <= 4) return 4;
    if (w <= 8) return 8;
    return 16;
  endfunction

  function automatic int ebr_depth(input int w);
    return EBR_BITS / ebr_lane(w);
  endfunction

  function automatic bit geom_ok(input int w, input int d);
    return is_pow2(d) &&
      (d >= EBR_MIN_DEPTH) && (d <= EBR_MAX_DEPTH) &&
      (w >= 1) && (w <= EBR_MAX_W);
  endfunction

endpackage

// File: rtl/ebr_sdp_ram.sv
// Simple dual-port RAM with registered read, shaped to map onto SB_RAM40_4K.
// Contents are never reset.
module ebr_sdp_ram
  import ebr_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ebr_stream_fifo.sv
// Valid/ready elastic buffer over one inferred EBR; head word lives in the RAM read register.
// EBR_FIFO_WATERMARK_EN adds peak_level, peak_clr and ovf_err.
module ebr_stream_fifo
  import ebr_fifo_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 256,
  parameter int AFULL_THRESH = DEPTH - 4,
  localparam int AW          = clog2(DEPTH),
  localparam int LW          = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LW-1:0]     level,
  output logic              almost_full
`ifdef EBR_FIFO_WATERMARK_EN
  ,
  input  logic              peak_clr,
  output logic [LW-1:0]     peak_level,
  output logic              ovf_err
`endif
);

  if (!geom_ok(DATA_W, DEPTH)) begin : g_bad_geom
    $error("ebr_stream_fifo: illegal DATA_W/DEPTH");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thr
    $error("ebr_stream_fifo: illegal AFULL_THRESH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] mem_cnt;
  logic [LW-1:0] mem_cnt_nxt;
  logic [LW-1:0] lvl_q;
  logic [LW-1:0] lvl_nxt;
  logic          mv_q;
  logic          mv_nxt;
  logic          af_q;
  logic          init_q;

  logic push;
  logic pop;
  logic re;
  logic l_inc;
  logic l_dec;
  logic c_inc;
  logic c_dec;

  // Ready comes only from registered state; no m_ready path.
  assign s_ready = init_q & (lvl_q < LW'(DEPTH));
  assign push    = s_valid & s_ready & ~flush;
  assign pop     = mv_q & m_ready;
  assign re      = (mem_cnt != '0) & (~mv_q | m_ready) & ~flush;

  assign l_inc = push & ~pop;
  assign l_dec = pop & ~push & ~flush;
  assign c_inc = push & ~re;
  assign c_dec = re & ~push;

  always_comb begin
    lvl_nxt = lvl_q;
    unique case (1'b1)
      flush:   lvl_nxt = '0;
      l_inc:   lvl_nxt = lvl_q + LW'(1);
      l_dec:   lvl_nxt = lvl_q - LW'(1);
      default: lvl_nxt = lvl_q;
    endcase
  end

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    unique case (1'b1)
      flush:   mem_cnt_nxt = '0;
      c_inc:   mem_cnt_nxt = mem_cnt + LW'(1);
      c_dec:   mem_cnt_nxt = mem_cnt - LW'(1);
      default: mem_cnt_nxt = mem_cnt;
    endcase
  end

  always_comb begin
    mv_nxt = mv_q;
    if (flush)    mv_nxt = 1'b0;
    else if (re)  mv_nxt = 1'b1;
    else if (pop) mv_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      lvl_q   <= '0;
      mv_q    <= 1'b0;
      af_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      mem_cnt <= mem_cnt_nxt;
      lvl_q   <= lvl_nxt;
      mv_q    <= mv_nxt;
      af_q    <= lvl_nxt >= LW'(AFULL_THRESH);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (re)   rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  ebr_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (s_data),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (m_data)
  );

  assign m_valid     = mv_q;
  assign level       = lvl_q;
  assign almost_full = af_q;

`ifdef EBR_FIFO_WATERMARK_EN
  logic [LW-1:0] peak_q;
  logic          ovf_q;

  // Peak follows the level register, so it lags level by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      peak_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (peak_clr)            peak_q <= lvl_q;
      else if (lvl_q > peak_q) peak_q <= lvl_q;
      if (init_q & s_valid & ~s_ready) ovf_q <= 1'b1;
    end
  end

  assign peak_level = peak_q;
  assign ovf_err    = ovf_q;
`endif

endmodule

// File: tb/tb_ebr_stream_fifo.sv
// Directed bench for ebr_stream_fifo with a queue scoreboard.
// Build with EBR_FIFO_WATERMARK_EN to also cover the watermark outputs.
module tb_ebr_stream_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;
  logic          almost_full;
`ifdef EBR_FIFO_WATERMARK_EN
  logic          peak_clr = 1'b0;
  logic [LW-1:0] peak_level;
  logic          ovf_err;
`endif

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int pops0;
  logic [DW-1:0] q[$];

  ebr_stream_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .almost_full (almost_full)
`ifdef EBR_FIFO_WATERMARK_EN
    ,
    .peak_clr    (peak_clr),
    .peak_level  (peak_level),
    .ovf_err     (ovf_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Inputs change at posedge+2, so the negedge sees the handshake the next edge commits.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (m_valid && m_ready) begin
        pops++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none", m_data);
        end else begin
          chk("data_order", 32'(m_data), 32'(q.pop_front()));
        end
      end
      if (s_valid && s_ready) q.push_back(s_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_s_ready", 32'(s_ready), 32'd1);
    chk("rel_m_valid", 32'(m_valid), 32'd0);
    chk("rel_level", 32'(level), 32'd0);
    chk("rel_afull", 32'(almost_full), 32'd0);

    s_valid = 1'b1;
    s_data  = 16'hA5A5;
    step();
    s_valid = 1'b0;
    chk("lat_level", 32'(level), 32'd1);
    chk("lat_m_valid_early", 32'(m_valid), 32'd0);
    step();
    chk("lat_m_valid", 32'(m_valid), 32'd1);
    chk("lat_m_data", 32'(m_data), 32'h0000A5A5);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pop1_level", 32'(level), 32'd0);
    chk("pop1_m_valid", 32'(m_valid), 32'd0);

    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
      chk("fill_s_ready", 32'(s_ready), 32'((i + 1) < 16));
    end
    s_data = 16'h0011;
    step();
    chk("full_level", 32'(level), 32'd16);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_head", 32'(m_data), 32'd0);
`ifdef EBR_FIFO_WATERMARK_EN
    chk("peak_full", 32'(peak_level), 32'd16);
    chk("ovf_set", 32'(ovf_err), 32'd1);
`endif

    m_ready = 1'b1;
    pops0 = pops;
    for (int k = 0; k < 64; k++) begin
      s_data = 16'h0100 + DW'(k);
      step();
      chk("stream_level_band", 32'(level >= 15 && level <= 16), 32'd1);
    end
    chk("stream_no_gaps", 32'(pops - pops0), 32'd64);
    s_valid = 1'b0;
    repeat (20) step();
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_m_valid", 32'(m_valid), 32'd0);
    chk("drain_no_loss", 32'(q.size()), 32'd0);

    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0200 + DW'(i);
      step();
    end
    chk("pre_flush_level", 32'(level), 32'd9);
    flush  = 1'b1;
    s_data = 16'hBEEF;
    #1;
    chk("flush_s_ready", 32'(s_ready), 32'd1);
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_afull", 32'(almost_full), 32'd0);
    m_ready = 1'b1;
    repeat (3) step();
    chk("flush_no_beef", 32'(m_valid), 32'd0);
`ifdef EBR_FIFO_WATERMARK_EN
    chk("flush_peak", 32'(peak_level), 32'd0);
    chk("flush_ovf", 32'(ovf_err), 32'd0);
`endif

    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0300 + DW'(i);
      step();
    end
    chk("burst_level", 32'(level), 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_afull", 32'(almost_full), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rerel_s_ready", 32'(s_ready), 32'd1);
    chk("rerel_level", 32'(level), 32'd0);
`ifdef EBR_FIFO_WATERMARK_EN
    chk("rerel_peak", 32'(peak_level), 32'd0);
    chk("rerel_ovf", 32'(ovf_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
